alu_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one instance of the team's 32-bit integer ALU between `NREQ` requesters, for example the execute stage and the branch/address unit. Each requester issues an operand/opcode request over a valid/ready handshake. The block grants one request at a time, registers its operands, evaluates them on the ALU, and holds the registered result and branch flag on a per-requester response handshake until that requester accepts it. Exactly one operation is in flight at any time.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu.sv | 38 +++
 rtl/alu_arb.sv | 138 +++++++++++++
 tb/tb_alu_arb.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: operand width, opcode encoding
// and the sequencer state encoding.
package alu_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned OPW  = 4;

   localparam logic [OPW-1:0] OP_ADD   = 4'd0;
   localparam logic [OPW-1:0] OP_SUB   = 4'd1;
   localparam logic [OPW-1:0] OP_MUL   = 4'd2;
   localparam logic [OPW-1:0] OP_AND   = 4'd3;
   localparam logic [OPW-1:0] OP_OR    = 4'd4;
   localparam logic [OPW-1:0] OP_SL    = 4'd5;
   localparam logic [OPW-1:0] OP_SR    = 4'd6;
   localparam logic [OPW-1:0] OP_SLT   = 4'd7;
   localparam logic [OPW-1:0] OP_SLTU  = 4'd8;
   localparam logic [OPW-1:0] OP_AUIPC = 4'd9;
   localparam logic [OPW-1:0] OP_BEQ   = 4'd10;
   localparam logic [OPW-1:0] OP_BGT   = 4'd11;
   localparam logic [OPW-1:0] OP_BLT   = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU; branch ops report only the compare flag,
// and undefined opcodes fall back to a+b.
module alu
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [OPW-1:0]  op,
   output logic [XLEN-1:0] result_c,
   output logic            branch_c
);

   logic [4:0] shamt;

   assign shamt = b[4:0];

   always_comb begin
      result_c = '0;
      branch_c = 1'b0;
      case (op)
         OP_ADD:   result_c = a + b;
         OP_SUB:   result_c = a - b;
         OP_MUL:   result_c = a * b;
         OP_AND:   result_c = a & b;
         OP_OR:    result_c = a | b;
         OP_SL:    result_c = a << shamt;
         OP_SR:    result_c = a >> shamt;
         OP_SLT:   result_c = XLEN'($signed(a) < $signed(b));
         OP_SLTU:  result_c = XLEN'(a < b);
         OP_AUIPC: result_c = a + b;
         OP_BEQ:   branch_c = (a == b);
         OP_BGT:   branch_c = (a > b);
         OP_BLT:   branch_c = (a < b);
         default:  result_c = a + b;
      endcase
   end

endmodule

// File: rtl/alu_arb.sv
// Round-robin arbiter/sequencer sharing one ALU between NREQ requesters,
// one operation in flight: IDLE (grant) -> EXEC (evaluate) -> RESP (hold).
module alu_arb
   import alu_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned XLEN = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*XLEN-1:0] req_a,
   input  logic [NREQ*XLEN-1:0] req_b,
   input  logic [NREQ*OPW-1:0]  req_op,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [XLEN-1:0]      rsp_result,
   output logic                 rsp_branch,
   output logic                 busy
);

   localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e          state_q, state_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [IDXW-1:0] grant_q, grant_d;
   logic [IDXW-1:0] pick_c;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [OPW-1:0]  op_q, op_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            branch_q, branch_d;
   logic            busy_q, busy_d;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0] alu_result_c;
   logic            alu_branch_c;

   // First set bit at or above ptr, wrapping; the lowest offset wins.
   function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                                input logic [IDXW-1:0] ptr);
      logic [IDXW-1:0] pick;
      int unsigned     idx;
      pick = ptr;
      for (int off = int'(NREQ) - 1; off >= 0; off--) begin
         idx = (int'(ptr) + off) % NREQ;
         if (valid[idx]) pick = IDXW'(idx);
      end
      return pick;
   endfunction

   alu u_alu (
      .a        (a_q),
      .b        (b_q),
      .op       (op_q),
      .result_c (alu_result_c),
      .branch_c (alu_branch_c)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      result_d    = result_q;
      branch_d    = branch_q;
      rsp_valid_d = rsp_valid_q;
      req_ready   = '0;
      pick_c      = rr_pick(req_valid, ptr_q);

      case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               req_ready[pick_c] = 1'b1;
               a_d     = req_a[XLEN*pick_c +: XLEN];
               b_d     = req_b[XLEN*pick_c +: XLEN];
               op_d    = req_op[OPW*pick_c +: OPW];
               grant_d = pick_c;
               ptr_d   = (pick_c == IDXW'(NREQ - 1)) ? '0 : pick_c + IDXW'(1);
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            result_d             = alu_result_c;
            branch_d             = alu_branch_c;
            rsp_valid_d[grant_q] = 1'b1;
            state_d              = ST_RESP;
         end
         ST_RESP: begin
            // Only the granted requester's rsp_ready can close the transaction.
            if (rsp_ready[grant_q]) begin
               rsp_valid_d = '0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            rsp_valid_d = '0;
            state_d     = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         grant_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         result_q    <= '0;
         branch_q    <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         result_q    <= result_d;
         branch_q    <= branch_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = result_q;
   assign rsp_branch = branch_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb (NREQ=2): directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_alu_arb;

   localparam int NREQ = 2;

   logic            clk;
   logic            rst_n;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [63:0]     req_a;
   logic [63:0]     req_b;
   logic [7:0]      req_op;
   logic [1:0]      rsp_valid;
   logic [1:0]      rsp_ready;
   logic [31:0]     rsp_result;
   logic            rsp_branch;
   logic            busy;

   int checks = 0;
   int passed = 0;

   alu_arb #(.NREQ(2), .XLEN(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_branch (rsp_branch),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU computed directly from the opcode table.
   function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] r,
                                   output logic br);
      logic [63:0] p;
      int          sa;
      int          sb;
      r  = 32'd0;
      br = 1'b0;
      sa = a;
      sb = b;
      case (int'(op))
         0:  r = a + b;
         1:  r = a - b;
         2:  begin p = 64'(a) * 64'(b); r = p[31:0]; end
         3:  r = a & b;
         4:  r = a | b;
         5:  r = a << b[4:0];
         6:  r = a >> b[4:0];
         7:  r = (sa < sb) ? 32'd1 : 32'd0;
         8:  r = (a < b) ? 32'd1 : 32'd0;
         9:  r = a + b;
         10: br = (a == b);
         11: br = (a > b);
         12: br = (a < b);
         default: r = a + b;
      endcase
   endfunction

   task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
      req_op[i*4 +: 4]  = op;
      req_valid[i]      = 1'b1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_result !== 32'd0 ||
          rsp_branch !== 1'b0 || busy !== 1'b0)
         $display("FAIL reset_values: rdy=%b rv=%b res=%h br=%b busy=%b required 00 00 0 0 0",
                  req_ready, rsp_valid, rsp_result, rsp_branch, busy);
      else passed++;
      apply_reset();
   endtask

   task automatic test_single_op();
      apply_reset();
      set_req(0, 4'd0, 32'd5, 32'd7);
      #1;
      checks++;
      if (req_ready !== 2'b01) $display("FAIL single_grant: req_ready=%b required 01", req_ready);
      else passed++;
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++;
      if (rsp_valid !== 2'b00 || busy !== 1'b1)
         $display("FAIL single_exec: rsp_valid=%b busy=%b required 00 1", rsp_valid, busy);
      else passed++;
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 2'b01 || rsp_result !== 32'd12 || rsp_branch !== 1'b0)
         $display("FAIL single_resp: rv=%b res=%0d br=%b required 01 12 0",
                  rsp_valid, rsp_result, rsp_branch);
      else passed++;
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;
      #1;
      checks++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0)
         $display("FAIL single_done: rv=%b busy=%b required 00 0", rsp_valid, busy);
      else passed++;
   endtask

   task automatic test_contention();
      apply_reset();
      set_req(0, 4'd1, 32'd10, 32'd3);
      set_req(1, 4'd10, 32'd4, 32'd4);
      #1;
      checks++;
      if (req_ready !== 2'b01) $display("FAIL cont_grant0: req_ready=%b required 01", req_ready);
      else passed++;
      @(negedge clk);
      req_valid[0] = 1'b0;
      #1;
      checks++;
      if (req_ready !== 2'b00) $display("FAIL cont_exec_rdy: req_ready=%b required 00", req_ready);
      else passed++;
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 2'b01 || rsp_result !== 32'd7)
         $display("FAIL cont_resp0: rv=%b res=%0d required 01 7", rsp_valid, rsp_result);
      else passed++;
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;
      #1;
      checks++;
      if (req_ready !== 2'b10) $display("FAIL cont_grant1: req_ready=%b required 10", req_ready);
      else passed++;
      @(negedge clk);
      req_valid[1] = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 2'b00) $display("FAIL cont_early1: rsp_valid=%b required 00", rsp_valid);
      else passed++;
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 2'b10 || rsp_result !== 32'd0 || rsp_branch !== 1'b1)
         $display("FAIL cont_resp1: rv=%b res=%0d br=%b required 10 0 1",
                  rsp_valid, rsp_result, rsp_branch);
      else passed++;
      rsp_ready = 2'b10;
      @(negedge clk);
      rsp_ready = 2'b00;
   endtask

   task automatic test_fairness();
      int grants[$];
      apply_reset();
      set_req(0, 4'd0, 32'd1, 32'd2);
      set_req(1, 4'd4, 32'd8, 32'd1);
      rsp_ready = 2'b11;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (req_ready == 2'b01) grants.push_back(0);
         else if (req_ready == 2'b10) grants.push_back(1);
         else if (req_ready != 2'b00) grants.push_back(9);
         @(negedge clk);
      end
      req_valid = '0;
      rsp_ready = '0;
      checks++;
      if (grants.size() != 4) $display("FAIL fair_count: grants=%0d required 4", grants.size());
      else passed++;
      for (int k = 0; k < grants.size(); k++) begin
         checks++;
         if (grants[k] != k % 2)
            $display("FAIL fair_seq%0d: grant=%0d required %0d", k, grants[k], k % 2);
         else passed++;
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      set_req(0, 4'd7, 32'hFFFF_FFFF, 32'd1);
      set_req(1, 4'd0, 32'd1, 32'd1);
      #1;
      checks++;
      if (req_ready !== 2'b01) $display("FAIL bp_grant: req_ready=%b required 01", req_ready);
      else passed++;
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (rsp_valid !== 2'b01 || rsp_result !== 32'd1 || req_ready !== 2'b00)
            $display("FAIL bp_hold%0d: rv=%b res=%h rdy=%b required 01 1 00",
                     k, rsp_valid, rsp_result, req_ready);
         else passed++;
         @(negedge clk);
      end
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;
      #1;
      checks++;
      if (rsp_valid !== 2'b00 || req_ready !== 2'b10)
         $display("FAIL bp_release: rv=%b rdy=%b required 00 10", rsp_valid, req_ready);
      else passed++;
   endtask

   task automatic test_reset_in_exec();
      apply_reset();
      set_req(0, 4'd5, 32'd1, 32'd31);
      #1;
      checks++;
      if (req_ready !== 2'b01) $display("FAIL rst_grant: req_ready=%b required 01", req_ready);
      else passed++;
      @(negedge clk);
      req_valid = '0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_result !== 32'd0 || rsp_branch !== 1'b0)
         $display("FAIL rst_immediate: rv=%b busy=%b res=%h br=%b required 00 0 0 0",
                  rsp_valid, busy, rsp_result, rsp_branch);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         checks++;
         if (rsp_valid !== 2'b00 || busy !== 1'b0)
            $display("FAIL rst_no_resp%0d: rv=%b busy=%b required 00 0", k, rsp_valid, busy);
         else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_edge_ops();
      logic [3:0]  ops[3];
      logic [31:0] as[3];
      logic [31:0] bs[3];
      logic [31:0] exp_r[3];
      ops = '{4'd6, 4'd2, 4'd15};
      as  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
      bs  = '{32'd4, 32'd2, 32'd3};
      exp_r = '{32'h0800_0000, 32'hFFFF_FFFE, 32'd5};
      apply_reset();
      rsp_ready = 2'b01;
      for (int e = 0; e < 3; e++) begin
         set_req(0, ops[e], as[e], bs[e]);
         #1;
         checks++;
         if (req_ready !== 2'b01)
            $display("FAIL edge_cadence%0d: req_ready=%b required 01", e, req_ready);
         else passed++;
         @(negedge clk);
         req_valid = '0;
         @(negedge clk);
         #1;
         checks++;
         if (rsp_valid !== 2'b01 || rsp_result !== exp_r[e] || rsp_branch !== 1'b0)
            $display("FAIL edge_op%0d: rv=%b res=%h br=%b required 01 %h 0",
                     e, rsp_valid, rsp_result, rsp_branch, exp_r[e]);
         else passed++;
         @(negedge clk);
      end
      rsp_ready = '0;
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 4))
         0: return 32'($urandom_range(0, 40));
         1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
         2: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Transaction model: whoever wins arbitration gets its response two cycles
   // later, held until accepted; the next grant waits for the following cycle.
   task automatic test_random();
      bit          inflight = 0;
      int          age = 0;
      int          owner = 0;
      int          ptr_m = 0;
      int          win;
      logic [1:0]  pend = '0;
      logic [1:0]  exp_rdy;
      logic [1:0]  exp_rv;
      logic [31:0] exp_res = '0;
      logic        exp_br = 1'b0;
      logic [31:0] opa;
      logic [31:0] opb;
      apply_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 2) != 0) begin
               set_req(i, 4'($urandom_range(0, 15)), rand_operand(), rand_operand());
               pend[i] = 1'b1;
            end
         end
         req_valid = pend;
         rsp_ready = 2'($urandom_range(0, 3));
         #1;
         win = -1;
         if (!inflight) begin
            for (int k = 0; k < NREQ; k++) begin
               if (win < 0 && pend[(ptr_m + k) % NREQ]) win = (ptr_m + k) % NREQ;
            end
         end
         exp_rdy = '0;
         if (win >= 0) exp_rdy[win] = 1'b1;
         exp_rv = '0;
         if (inflight && age >= 2) exp_rv[owner] = 1'b1;
         checks++;
         if (req_ready !== exp_rdy || rsp_valid !== exp_rv || busy !== inflight)
            $display("FAIL rand_ctl@%0d: rdy=%b rv=%b busy=%b required %b %b %b",
                     cyc, req_ready, rsp_valid, busy, exp_rdy, exp_rv, inflight);
         else passed++;
         if (exp_rv != 0) begin
            checks++;
            if (rsp_result !== exp_res || rsp_branch !== exp_br)
               $display("FAIL rand_data@%0d: res=%h br=%b required %h %b",
                        cyc, rsp_result, rsp_branch, exp_res, exp_br);
            else passed++;
         end
         @(posedge clk);
         if (win >= 0) begin
            opa = req_a[win*32 +: 32];
            opb = req_b[win*32 +: 32];
            ref_alu(req_op[win*4 +: 4], opa, opb, exp_res, exp_br);
            inflight  = 1;
            age       = 1;
            owner     = win;
            ptr_m     = (win + 1) % NREQ;
            pend[win] = 1'b0;
         end else if (inflight) begin
            if (age >= 2 && rsp_ready[owner]) inflight = 0;
            else age++;
         end
         @(negedge clk);
      end
      req_valid = '0;
      rsp_ready = '0;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      test_reset();
      test_single_op();
      test_contention();
      test_fairness();
      test_backpressure();
      test_reset_in_exec();
      test_edge_ops();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
